// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: round-robin N-port arbiter in front of a single LC-3b memory port.
// Latency: one added cycle per access (request seen in IDLE at edge t -> downstream strobe from t+1).
// Backpressure: one access in flight; other requesters wait, holding their request, until their port_resp.
//
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   port_read/port_write               per-port request strobes (NUM_PORTS bits)
//   port_address/port_wdata/
//   port_byte_enable                   per-port fields, port i at [i*W +: W]
//   port_resp                          per-port completion pulse (mem_resp routed to the owner)
//   port_rdata                         read data broadcast to all ports
//   grant                              one-hot owner of the in-flight access, zero when idle
//   mem_*                              single downstream memory port
module lc3b_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             port_read,
    input  logic [NUM_PORTS-1:0]             port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_byte_enable,
    output logic [NUM_PORTS-1:0]             port_resp,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [MASK_WIDTH-1:0]            mem_byte_enable,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    // Pointer is kept at least one bit wide so NUM_PORTS=1 still elaborates;
    // in that case it simply never leaves zero.
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;

    logic [NUM_PORTS-1:0] req;
    logic                 found;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [NUM_PORTS-1:0] win_oh;
    logic                 sel_read;
    logic                 sel_write;

    assign req = port_read | port_write;

    // Rotating priority search: the first requester at or above rr_ptr wins,
    // wrapping around to port 0.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    assign next_ptr  = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
    assign sel_read  = port_read[win_idx];
    assign sel_write = port_write[win_idx];

    // Completion goes only to the owner; grant is zero outside BUSY, so a
    // stray mem_resp while idle never reaches a requester.
    assign port_resp  = grant & {NUM_PORTS{mem_resp}};
    assign port_rdata = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state           <= BUSY;
                        grant           <= win_oh;
                        rr_ptr          <= next_ptr;
                        // A port asserting both strobes is treated as a write.
                        mem_write       <= sel_write;
                        mem_read        <= sel_read & ~sel_write;
                        mem_address     <= port_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata       <= port_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        mem_byte_enable <= port_byte_enable[win_idx*MASK_WIDTH +: MASK_WIDTH];
                    end
                end
                BUSY: begin
                    // Upstream is ignored here; address/data/mask stay latched
                    // and keep their value after the access, only strobes clear.
                    if (mem_resp) begin
                        state     <= IDLE;
                        grant     <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
module tb_lc3b_mem_arbiter;

    logic clk;
    logic reset;

    // NUM_PORTS=2 instance
    logic [1:0]  p_rd2, p_wr2, pr2, g2;
    logic [31:0] p_addr2, p_wd2;
    logic [3:0]  p_be2;
    logic [15:0] prd2, ma2, mwd2;
    logic        mr2, mw2;
    logic [1:0]  mbe2;

    // NUM_PORTS=4 instance
    logic [3:0]  p_rd4, p_wr4, pr4, g4;
    logic [63:0] p_addr4, p_wd4;
    logic [7:0]  p_be4;
    logic [15:0] prd4, ma4, mwd4;
    logic        mr4, mw4;
    logic [1:0]  mbe4;

    logic        mresp [2];
    logic [15:0] mrdata[2];

    lc3b_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset),
        .port_read(p_rd2), .port_write(p_wr2), .port_address(p_addr2),
        .port_wdata(p_wd2), .port_byte_enable(p_be2),
        .port_resp(pr2), .port_rdata(prd2), .grant(g2),
        .mem_read(mr2), .mem_write(mw2), .mem_address(ma2),
        .mem_wdata(mwd2), .mem_byte_enable(mbe2),
        .mem_resp(mresp[0]), .mem_rdata(mrdata[0])
    );

    lc3b_mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut4 (
        .clk(clk), .reset(reset),
        .port_read(p_rd4), .port_write(p_wr4), .port_address(p_addr4),
        .port_wdata(p_wd4), .port_byte_enable(p_be4),
        .port_resp(pr4), .port_rdata(prd4), .grant(g4),
        .mem_read(mr4), .mem_write(mw4), .mem_address(ma4),
        .mem_wdata(mwd4), .mem_byte_enable(mbe4),
        .mem_resp(mresp[1]), .mem_rdata(mrdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        logic [15:0] rdata;
    } rec_t;

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        logic [15:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    rec_t        cur[2];
    logic        busy[2], idle_chk[2], b2b[2];
    int          resp_cyc[2];
    logic [3:0]  resp_seen[2];
    int          cnt[2];
    int          issued[2][4], done[2][4];
    logic        rd_a[2][4], wr_a[2][4];
    logic [15:0] addr_a[2][4], wd_a[2][4];
    logic [1:0]  be_a[2][4];
    int          cyc, checks, errors;

    // last samples of the 2-port instance, taken at the falling edge
    logic [1:0]  s_g, s_pr;
    logic        s_mr;
    logic [15:0] s_ma, s_prd;

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", d, name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] oh(input int p);
        return 4'b0001 << p;
    endfunction

    task automatic push(input int d, input rec_t r);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            p_rd2[i]          = (issued[0][i] != done[0][i]) && rd_a[0][i];
            p_wr2[i]          = (issued[0][i] != done[0][i]) && wr_a[0][i];
            p_addr2[i*16 +: 16] = addr_a[0][i];
            p_wd2[i*16 +: 16]   = wd_a[0][i];
            p_be2[i*2 +: 2]     = be_a[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            p_rd4[i]          = (issued[1][i] != done[1][i]) && rd_a[1][i];
            p_wr4[i]          = (issued[1][i] != done[1][i]) && wr_a[1][i];
            p_addr4[i*16 +: 16] = addr_a[1][i];
            p_wd4[i*16 +: 16]   = wd_a[1][i];
            p_be4[i*2 +: 2]     = be_a[1][i];
        end
    endtask

    // Scoreboard monitor: pops the expected access when a grant appears and
    // checks the downstream fields and completion routing every cycle.
    task automatic mon(input int d, input logic [3:0] g, input logic [3:0] pr,
                       input logic mrd, input logic mwr, input logic [15:0] ma,
                       input logic [15:0] mwd, input logic [1:0] mbe,
                       input logic [15:0] prd, input logic mrs);
        logic [3:0] exp_pr;
        int qs;
        if (idle_chk[d]) begin
            chk(d, "grant_after_resp", g, 0);
            chk(d, "strobes_after_resp", {mrd, mwr}, 0);
            idle_chk[d] = 1'b0;
        end else if (!busy[d] && g != 0) begin
            if (b2b[d] && resp_cyc[d] >= 0) chk(d, "b2b_gap", cyc - resp_cyc[d], 2);
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected_grant: got %b expected no grant", d, g);
                cur[d] = '{port:0, rd:1'b0, wr:1'b0, addr:16'h0, wdata:16'h0, be:2'b0, lat:1, rdata:16'h0};
            end else if (d == 0) begin
                cur[d] = q0.pop_front();
            end else begin
                cur[d] = q1.pop_front();
            end
            busy[d] = 1'b1;
        end
        if (busy[d]) begin
            chk(d, "grant", g, oh(cur[d].port));
            chk(d, "strobes_rd_wr", {mrd, mwr}, {cur[d].rd, cur[d].wr});
            chk(d, "mem_address", ma, cur[d].addr);
            chk(d, "mem_wdata", mwd, cur[d].wdata);
            chk(d, "mem_byte_enable", mbe, cur[d].be);
        end
        exp_pr = (busy[d] && mrs) ? oh(cur[d].port) : 4'b0000;
        chk(d, "port_resp", pr, exp_pr);
        resp_seen[d] = pr;
        if (busy[d] && mrs) begin
            chk(d, "port_rdata", prd, cur[d].rdata);
            busy[d]     = 1'b0;
            idle_chk[d] = 1'b1;
            resp_cyc[d] = cyc;
        end
    endtask

    // Memory model: completes an access in its (lat+1)-th strobe cycle.
    task automatic model(input int d, input logic strobe);
        if (mresp[d]) begin
            mresp[d]  = 1'b0;
            cnt[d]    = 0;
            mrdata[d] = ~cur[d].rdata;
        end else if (strobe) begin
            cnt[d]++;
            if (cnt[d] == cur[d].lat + 1) begin
                mresp[d]  = 1'b1;
                mrdata[d] = cur[d].rdata;
            end
        end else begin
            cnt[d] = 0;
        end
    endtask

    task automatic tick();
        apply();
        @(negedge clk);
        mon(0, {2'b00, g2}, {2'b00, pr2}, mr2, mw2, ma2, mwd2, mbe2, prd2, mresp[0]);
        s_g = g2; s_pr = pr2; s_mr = mr2; s_ma = ma2; s_prd = prd2;
        mon(1, g4, pr4, mr4, mw4, ma4, mwd4, mbe4, prd4, mresp[1]);
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (resp_seen[d][i]) done[d][i]++;
        model(0, mr2 | mw2);
        model(1, mr4 | mw4);
    endtask

    function automatic logic pending();
        logic p;
        p = (q0.size() != 0) || (q1.size() != 0) || busy[0] || busy[1];
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (issued[d][i] != done[d][i]) p = 1'b1;
        return p;
    endfunction

    task automatic hard_reset();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; idle_chk[d] = 1'b0; b2b[d] = 1'b0;
            cnt[d] = 0; mresp[d] = 1'b0;
            for (int i = 0; i < 4; i++) done[d][i] = issued[d][i];
        end
        q0.delete();
        q1.delete();
        apply();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            tick();
            n++;
        end
        if (pending()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: accesses still outstanding after %0d cycles", maxc);
            hard_reset();
        end
        tick();
    endtask

    task automatic issue(input int d, input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] b, input int n);
        rd_a[d][p] = r; wr_a[d][p] = w;
        addr_a[d][p] = a; wd_a[d][p] = wd; be_a[d][p] = b;
        issued[d][p] += n;
    endtask

    task automatic expect_acc(input int d, input int p, input logic er, input logic ew,
                              input int lat, input logic [15:0] rdv);
        rec_t r;
        r.port = p; r.rd = er; r.wr = ew;
        r.addr = addr_a[d][p]; r.wdata = wd_a[d][p]; r.be = be_a[d][p];
        r.lat = lat; r.rdata = rdv;
        push(d, r);
    endtask

    vec_t vt[6];

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; idle_chk[d] = 1'b0; b2b[d] = 1'b0; resp_cyc[d] = -1;
            resp_seen[d] = 4'b0; cnt[d] = 0; mresp[d] = 1'b0; mrdata[d] = 16'h0;
            cur[d] = '{port:0, rd:1'b0, wr:1'b0, addr:16'h0, wdata:16'h0, be:2'b0, lat:1, rdata:16'h0};
            for (int i = 0; i < 4; i++) begin
                issued[d][i] = 0; done[d][i] = 0; rd_a[d][i] = 1'b0; wr_a[d][i] = 1'b0;
                addr_a[d][i] = 16'h0; wd_a[d][i] = 16'h0; be_a[d][i] = 2'b0;
            end
        end

        //               port rd    wr    addr      wdata     be     lat rdata     exp_rd exp_wr
        vt[0] = '{0, 1'b1, 1'b0, 16'h2000, 16'h0000, 2'b11, 1, 16'h1111, 1'b1, 1'b0};
        vt[1] = '{1, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b10, 2, 16'h0000, 1'b0, 1'b1};
        vt[2] = '{0, 1'b1, 1'b1, 16'h3000, 16'h5A5A, 2'b01, 1, 16'h2222, 1'b0, 1'b1};
        vt[3] = '{1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b11, 4, 16'hCAFE, 1'b1, 1'b0};
        vt[4] = '{0, 1'b0, 1'b1, 16'h0002, 16'h1357, 2'b11, 2, 16'h0000, 1'b0, 1'b1};
        vt[5] = '{1, 1'b1, 1'b1, 16'h8000, 16'hFFFF, 2'b00, 1, 16'h4321, 1'b0, 1'b1};

        reset = 1'b1;
        apply();
        @(posedge clk);
        #1;
        chk(0, "rst_grant", g2, 0);
        chk(0, "rst_strobes", {mr2, mw2}, 0);
        chk(0, "rst_mem_address", ma2, 0);
        chk(0, "rst_mem_wdata", mwd2, 0);
        chk(0, "rst_mem_byte_enable", mbe2, 0);
        chk(0, "rst_port_resp", pr2, 0);
        chk(1, "rst_grant", g4, 0);
        chk(1, "rst_strobes", {mr4, mw4}, 0);
        chk(1, "rst_mem_address", ma4, 0);
        reset = 1'b0;

        // Port 0 reads 0x1234, memory answers 0xBEEF in the 4th strobe cycle.
        issue(0, 0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11, 1);
        expect_acc(0, 0, 1'b1, 1'b0, 3, 16'hBEEF);
        for (int c = 0; c <= 5; c++) begin
            tick();
            chk(0, $sformatf("t1_mem_read_c%0d", c), s_mr, (c >= 1 && c <= 4));
            chk(0, $sformatf("t1_grant_c%0d", c), s_g, (c >= 1 && c <= 4) ? 2'b01 : 2'b00);
            chk(0, $sformatf("t1_port_resp_c%0d", c), s_pr, (c == 4) ? 2'b01 : 2'b00);
            if (c >= 1 && c <= 4) chk(0, $sformatf("t1_mem_address_c%0d", c), s_ma, 16'h1234);
            if (c == 4) chk(0, "t1_port_rdata", s_prd, 16'hBEEF);
        end
        drain(10);

        for (int v = 0; v < 6; v++) begin
            issue(0, vt[v].port, vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].be, 1);
            expect_acc(0, vt[v].port, vt[v].exp_rd, vt[v].exp_wr, vt[v].lat, vt[v].rdata);
            drain(40);
        end

        // Port 1 write whose upstream fields change mid-access.
        issue(0, 1, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b10, 1);
        expect_acc(0, 1, 1'b0, 1'b1, 3, 16'h0000);
        tick();
        tick();
        addr_a[0][1] = 16'h9999; wd_a[0][1] = 16'h0000; be_a[0][1] = 2'b01; rd_a[0][1] = 1'b1;
        drain(20);
        chk(0, "idle_hold_address", ma2, 16'h0040);
        chk(0, "idle_hold_wdata", mwd2, 16'hA5A5);
        chk(0, "idle_hold_byte_enable", mbe2, 2'b10);

        // Stray mem_resp while idle.
        mresp[0] = 1'b1;
        mrdata[0] = 16'h7777;
        tick();
        chk(0, "idle_resp_grant", s_g, 0);
        chk(0, "idle_resp_port_resp", s_pr, 0);
        tick();
        chk(0, "idle_resp_no_strobe", s_mr, 0);

        // Ports 0 and 1 both hold two requests: strict alternation, back to back.
        issue(0, 0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11, 2);
        issue(0, 1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11, 2);
        expect_acc(0, 0, 1'b1, 1'b0, 2, 16'h0A0A);
        expect_acc(0, 1, 1'b1, 1'b0, 2, 16'h1B1B);
        expect_acc(0, 0, 1'b1, 1'b0, 1, 16'h0C0C);
        expect_acc(0, 1, 1'b1, 1'b0, 3, 16'h1D1D);
        b2b[0] = 1'b1; resp_cyc[0] = -1;
        drain(60);
        b2b[0] = 1'b0;

        // 4 ports: serve port 1 so the pointer sits at 2, then 1 and 3 compete.
        issue(1, 1, 1'b1, 1'b0, 16'h4001, 16'h0000, 2'b11, 1);
        expect_acc(1, 1, 1'b1, 1'b0, 1, 16'h4444);
        drain(20);
        issue(1, 1, 1'b0, 1'b1, 16'h4011, 16'h1111, 2'b11, 1);
        issue(1, 3, 1'b1, 1'b0, 16'h4033, 16'h0000, 2'b01, 1);
        expect_acc(1, 3, 1'b1, 1'b0, 2, 16'h3333);
        expect_acc(1, 1, 1'b0, 1'b1, 1, 16'h0000);
        drain(30);

        // All four ports request twice; pointer starts at 2.
        for (int i = 0; i < 4; i++)
            issue(1, i, 1'b1, 1'b0, 16'h5000 + 16'(i), 16'h0000, 2'b11, 2);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                expect_acc(1, (k + 2) % 4, 1'b1, 1'b0, 1, 16'h6000 + 16'(r * 4 + k));
        b2b[1] = 1'b1; resp_cyc[1] = -1;
        drain(100);
        b2b[1] = 1'b0;

        // Reset in the second busy cycle of a port 0 access.
        issue(0, 0, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b11, 1);
        expect_acc(0, 0, 1'b1, 1'b0, 6, 16'hDEAD);
        tick();
        tick();
        reset = 1'b1;
        mresp[0] = 1'b1;
        #1;
        chk(0, "rst_busy_mem_read", mr2, 0);
        chk(0, "rst_busy_grant", g2, 0);
        chk(0, "rst_busy_port_resp", pr2, 0);
        hard_reset();
        issue(0, 0, 1'b1, 1'b0, 16'h0310, 16'h0000, 2'b11, 1);
        issue(0, 1, 1'b1, 1'b0, 16'h0320, 16'h0000, 2'b11, 1);
        expect_acc(0, 0, 1'b1, 1'b0, 1, 16'h0E0E);
        expect_acc(0, 1, 1'b1, 1'b0, 1, 16'h0F0F);
        drain(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Parametrised N-port memory arbiter for LC-3b cores. It sits between several requesters (instruction fetch, data access, future cache fill/writeback ports) and the single physical memory port. Each requester sees the same read/write/resp handshake the core's control unit already drives. The block grants one request at a time, round-robin, latches it, forwards it downstream, and routes mem_resp back to the winner.

## Interface
- NUM_PORTS, 2, number of requester ports (1..8)
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 16, data width; multiple of 8
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)

Clock, reset, upstream ports, then downstream port:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- port_read  in  NUM_PORTS  per-port read request
- port_write  in  NUM_PORTS  per-port write request
- port_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- port_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data, same packing
- port_byte_enable  in  NUM_PORTS*MASK_WIDTH  per-port byte mask, same packing
- port_resp  out  NUM_PORTS  per-port completion pulse
- port_rdata  out  DATA_WIDTH  read data, broadcast to all ports
- grant  out  NUM_PORTS  one-hot owner of the in-flight access; all-zero when idle
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_byte_enable  out  MASK_WIDTH  downstream byte mask
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data

## Operation
- States: IDLE, BUSY.
- Port i is requesting when port_read[i] | port_write[i].
- IDLE, no requester: stay in IDLE.
- IDLE, at least one requester:
  - Select the first requesting port, searching upward from rr_ptr and wrapping modulo NUM_PORTS.
  - Latch that port's read, write, address, wdata and byte_enable.
  - Set grant to the port's one-hot and move to BUSY.
  - Set rr_ptr = (winner+1) mod NUM_PORTS.
- Both read and write asserted on the winning port: latched as a write; mem_read stays 0.
- BUSY:
  - mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable come from the latched registers.
  - Upstream inputs are ignored, so requester changes during BUSY have no effect.
- BUSY, mem_resp=1:
  - port_resp[winner]=1 in the same cycle, combinational from mem_resp & grant.
  - Next edge: clear mem_read/mem_write, clear grant, return to IDLE.
- port_rdata = mem_rdata at all times. It is valid only while port_resp is high.
- port_resp is never asserted in IDLE or to a non-granted port.
- Requesters hold their request until port_resp. A request still high on the cycle after port_resp is treated as a new request.
- NUM_PORTS=1: rr_ptr stays 0 and the block degenerates to a one-cycle request register.

## Timing
- Reset values:
  - State = IDLE, rr_ptr = 0, grant = 0.
  - mem_read = 0, mem_write = 0, mem_address = 0, mem_wdata = 0, mem_byte_enable = 0.
  - port_resp = 0.
- Reset asserted mid-BUSY aborts the access: the strobes drop asynchronously and no port_resp is issued.
- Request seen in IDLE at edge t: mem_read/mem_write high from cycle t+1.
- Added latency is one cycle per access.
- mem_resp in cycle k: port_resp in cycle k. IDLE at k+1; next grant at edge k+1; next downstream strobe at k+2.
- Back-to-back throughput: one access per (memory latency + 1) cycles.
- The latched mem_address/mem_wdata/mem_byte_enable hold their last value in IDLE. Only the strobes are cleared.
- mem_resp while IDLE is ignored.
- Fairness: with all NUM_PORTS continuously requesting, each port is granted exactly once per NUM_PORTS accesses.

## Test plan
- Reset, then port 0 reads address 0x1234 while memory returns 0xBEEF after 3 cycles.
  - Required: mem_read high cycles 1-4 with mem_address=0x1234.
  - Required: port_resp=2'b01 in cycle 4 with port_rdata=0xBEEF, and grant=0 at cycle 5.
- Ports 0 and 1 request in the same cycle and hold.
  - Required: grants alternate 0,1,0,1.
  - Required: port 1 is served right after port 0's resp+1 cycle, and never twice in a row.
- NUM_PORTS=4, ports 1 and 3 hold requests, rr_ptr=2.
  - Required: port 3 is granted first, then port 1.
- Port 1 writes 0xA5A5 with byte_enable 2'b10 to 0x0040, and changes its address during BUSY.
  - Required: downstream stays 0x0040/0xA5A5/2'b10 until mem_resp.
- Port 0 asserts read and write simultaneously.
  - Required: mem_write=1, mem_read=0.
- Reset pulsed in the second BUSY cycle.
  - Required: mem_read drops before the next clock edge, no port_resp occurs, and the next grant starts from port 0.
